// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and defaults for the SPI transmit master
package spi_master_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, DONE} state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CLK_DIV    = 4;

  // A divide-by-one still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// rtl/spi_sclk_divider.sv - half-period tick generator, restarts from zero when disabled
module spi_sclk_divider
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 transmit-only SPI master, MSB first, one-cycle done pulse
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs,
  output logic                  done
);

  localparam int            EW        = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_FALL = EW'(2 * DATA_WIDTH - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [EW-1:0]           edge_cnt;
  logic                    tick;
  logic                    div_en;

  assign div_en = (state == SETUP) || (state == TRANSFER);
  // The shift register MSB is the data line; it is cleared whenever the bus is idle.
  assign mosi   = shift_reg[DATA_WIDTH-1];

  spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (div_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      edge_cnt  <= '0;
      sclk      <= 1'b0;
      cs        <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= data_in;
            cs        <= 1'b0;
            edge_cnt  <= '0;
            state     <= SETUP;
          end else begin
            shift_reg <= '0;
            cs        <= 1'b1;
            sclk      <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk     <= 1'b1;
            edge_cnt <= EW'(1);
            state    <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (tick) begin
            // One extra low half-period follows the last fall before cs is released.
            if (edge_cnt == LAST_EDGE) begin
              state <= DONE;
            end else begin
              sclk     <= ~sclk;
              edge_cnt <= edge_cnt + 1'b1;
              if (sclk && edge_cnt != LAST_FALL) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          cs        <= 1'b1;
          done      <= 1'b1;
          sclk      <= 1'b0;
          shift_reg <= '0;
          edge_cnt  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master at CLK_DIV 4, 1 and 7
module tb_spi_master;

  localparam int W = 8;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   start_v = '0;
  logic [N-1:0]   sclk_v, mosi_v, cs_v, done_v;
  logic [W-1:0]   data_v [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_in(data_v[0]),
    .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs(cs_v[0]), .done(done_v[0]));

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_in(data_v[1]),
    .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs(cs_v[1]), .done(done_v[1]));

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(7)) u_div7 (
    .clk(clk), .rst(rst), .start(start_v[2]), .data_in(data_v[2]),
    .sclk(sclk_v[2]), .mosi(mosi_v[2]), .cs(cs_v[2]), .done(done_v[2]));

  function automatic int div_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  // Reference timing: cycle n counts clk edges after the accepting edge T0.
  // Rise k at (2k+1)*div, fall after bit k at (2k+2)*div, done at (2W+1)*div+1.
  task automatic run_frame(input int idx, input logic [W-1:0] d,
                           input int ignore_at, input int abort_rises);
    int div, done_at, n, rises, first_done;
    logic [W-1:0] got;
    logic prev_sclk;
    bit injected, cs_bad, fin, bad;
    div = div_of(idx);
    done_at = (2 * W + 1) * div + 1;
    n = 0; rises = 0; first_done = -1; prev_sclk = 1'b0; got = '0;
    injected = 0; cs_bad = 0; fin = 0;
    data_v[idx] = d;
    start_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    data_v[idx] = W'($urandom);
    checks++;
    if (cs_v[idx] !== 1'b0 || mosi_v[idx] !== d[W-1] || sclk_v[idx] !== 1'b0)
      begin errors++; $display("FAIL launch idx=%0d cs/mosi/sclk=%b%b%b want 0%b0", idx, cs_v[idx], mosi_v[idx], sclk_v[idx], d[W-1]); end
    while (!fin && n < done_at + 8) begin
      @(negedge clk);
      n++;
      if (injected) begin start_v[idx] = 1'b0; injected = 0; end
      if (n == ignore_at) begin start_v[idx] = 1'b1; data_v[idx] = '1; injected = 1; end
      if (sclk_v[idx] === 1'b1 && prev_sclk === 1'b0) begin
        checks++;
        if (n != (2 * rises + 1) * div)
          begin errors++; $display("FAIL rise_time idx=%0d rise=%0d got=%0d want=%0d", idx, rises, n, (2 * rises + 1) * div); end
        got = {got[W-2:0], mosi_v[idx]};
        rises++;
        if (abort_rises != 0 && rises == abort_rises) begin
          rst = 1'b1;
          @(negedge clk);
          checks++;
          if ({cs_v[idx], sclk_v[idx], mosi_v[idx], done_v[idx]} !== 4'b1000)
            begin errors++; $display("FAIL abort_state idx=%0d cs/sclk/mosi/done=%b%b%b%b want 1000", idx, cs_v[idx], sclk_v[idx], mosi_v[idx], done_v[idx]); end
          @(negedge clk);
          rst = 1'b0;
          bad = 0;
          repeat (done_at + 4) begin
            @(negedge clk);
            if (done_v[idx] !== 1'b0 || cs_v[idx] !== 1'b1 || sclk_v[idx] !== 1'b0) bad = 1;
          end
          checks++;
          if (bad) begin errors++; $display("FAIL abort_quiet idx=%0d bus active or done after reset, want idle", idx); end
          return;
        end
      end
      if (sclk_v[idx] === 1'b0 && prev_sclk === 1'b1) begin
        checks++;
        if (n != 2 * rises * div)
          begin errors++; $display("FAIL fall_time idx=%0d fall=%0d got=%0d want=%0d", idx, rises, n, 2 * rises * div); end
      end
      prev_sclk = sclk_v[idx];
      if (done_v[idx] === 1'b1) begin
        first_done = n;
        fin = 1;
        checks++;
        if (cs_v[idx] !== 1'b1 || mosi_v[idx] !== 1'b0 || sclk_v[idx] !== 1'b0)
          begin errors++; $display("FAIL done_bus idx=%0d cs/mosi/sclk=%b%b%b want 100", idx, cs_v[idx], mosi_v[idx], sclk_v[idx]); end
      end else if (cs_v[idx] !== 1'b0) begin
        cs_bad = 1;
      end
    end
    checks++;
    if (rises != W) begin errors++; $display("FAIL rise_count idx=%0d got=%0d want=%0d", idx, rises, W); end
    checks++;
    if (got !== d) begin errors++; $display("FAIL bits idx=%0d got=%h want=%h", idx, got, d); end
    checks++;
    if (first_done != done_at) begin errors++; $display("FAIL done_time idx=%0d got=%0d want=%0d", idx, first_done, done_at); end
    checks++;
    if (cs_bad) begin errors++; $display("FAIL cs_frame idx=%0d cs rose before done, want low", idx); end
  endtask

  task automatic test_reset();
    start_v = '0;
    for (int i = 0; i < N; i++) data_v[i] = '0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({sclk_v, mosi_v, cs_v, done_v} !== {3'b000, 3'b000, 3'b111, 3'b000})
        begin errors++; $display("FAIL reset_hold sclk=%b mosi=%b cs=%b done=%b want 000 000 111 000", sclk_v, mosi_v, cs_v, done_v); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sclk_v, mosi_v, cs_v, done_v} !== {3'b000, 3'b000, 3'b111, 3'b000})
      begin errors++; $display("FAIL reset_idle sclk=%b mosi=%b cs=%b done=%b want 000 000 111 000", sclk_v, mosi_v, cs_v, done_v); end
  endtask

  task automatic test_basic();
    run_frame(0, 8'hAA, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'h81, 0, 0);
    run_frame(0, 8'h3C, 0, 0);
  endtask

  task automatic test_ignore_busy();
    run_frame(0, 8'h55, 20, 0);
  endtask

  task automatic test_ignore_done();
    bit bad;
    run_frame(0, W'($urandom), (2 * W + 1) * 4, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (cs_v[0] !== 1'b1 || done_v[0] !== 1'b0 || sclk_v[0] !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL ignore_done start in done cycle began a frame or done repeated"); end
  endtask

  task automatic test_mid_reset();
    run_frame(0, 8'h5A, 0, 3);
    run_frame(0, 8'hC3, 0, 0);
  endtask

  task automatic test_param_sweep();
    for (int i = 1; i < N; i++)
      repeat (3) run_frame(i, W'($urandom), 0, 0);
  endtask

  task automatic test_random();
    repeat (4) run_frame(0, W'($urandom), 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_ignore_done();
    test_mid_reset();
    test_param_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
